// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I format codes, opcodes, immediate limits and encoder states
// LI_EXPAND_EN selects whether the LI_HI state exists.
package rv32_pkg;

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_S  = 3'd1;
    localparam logic [2:0] FMT_SB = 3'd2;
    localparam logic [2:0] FMT_UJ = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_LI = 3'd5;

    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SB_MIN    = -4096;
    localparam int SB_MAX    = 4094;
    localparam int UJ_MIN    = -(1 << 20);
    localparam int UJ_MAX    = (1 << 20) - 2;

    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

`ifdef LI_EXPAND_EN
    typedef enum logic {IDLE = 1'b0, LI_HI = 1'b1} state_t;
`else
    typedef enum logic {IDLE = 1'b0} state_t;
`endif

endpackage

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational RV32I field packer and immediate range checker
// Handles I/S/SB/UJ/U only; every other fmt code comes back as a rejected NOP.
module inst_pack #(
    parameter logic [31:0] NOP_WORD = rv32_pkg::NOP_WORD
) (
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] word,
    output logic        err
);
    import rv32_pkg::*;

    logic [31:0] off;

    // Branch/jump targets arrive absolute; the word carries the pc-relative offset.
    assign off = imm - pc;

    always_comb begin
        word = NOP_WORD;
        err  = 1'b1;
        case (fmt)
            FMT_I: begin
                err  = !in_range(imm, IMM12_MIN, IMM12_MAX);
                word = {imm[11:0], rs1, funct3, rd, opcode};
            end
            FMT_S: begin
                err  = !in_range(imm, IMM12_MIN, IMM12_MAX);
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            FMT_SB: begin
                err  = !in_range(off, SB_MIN, SB_MAX) || off[0];
                word = {off[12], off[10:5], rs2, rs1, funct3, off[4:1], off[11], opcode};
            end
            FMT_UJ: begin
                err  = !in_range(off, UJ_MIN, UJ_MAX) || off[0];
                word = {off[20], off[10:1], off[11], off[19:12], rd, opcode};
            end
            FMT_U: begin
                err  = (imm[11:0] != 12'd0);
                word = {imm[31:12], rd, opcode};
            end
            default: ;
        endcase
        if (err) begin
            word = NOP_WORD;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - registered valid/ready RV32I instruction encoder with LI expansion
// LI_EXPAND_EN builds the LUI+ADDI expansion; without it fmt=5 is rejected.
module inst_encoder #(
    parameter logic [31:0] NOP_WORD = rv32_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last
);
    import rv32_pkg::*;

    state_t      state, state_n;
    logic        out_valid_n, out_err_n, out_last_n;
    logic [31:0] out_inst_n;
    logic [31:0] pack_word;
    logic        pack_err;
    logic        accept, drain;

`ifdef LI_EXPAND_EN
    logic [11:0] lo_q, lo_n;
    logic [4:0]  rd_q, rd_n;
`endif

    inst_pack #(.NOP_WORD(NOP_WORD)) u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .funct3 (funct3),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm),
        .pc     (pc),
        .word   (pack_word),
        .err    (pack_err)
    );

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_comb begin
        state_n     = state;
        out_valid_n = out_valid;
        out_inst_n  = out_inst;
        out_err_n   = out_err;
        out_last_n  = out_last;
`ifdef LI_EXPAND_EN
        lo_n        = lo_q;
        rd_n        = rd_q;
`endif
        if (accept) begin
            out_valid_n = 1'b1;
            out_inst_n  = pack_word;
            out_err_n   = pack_err;
            out_last_n  = 1'b1;
`ifdef LI_EXPAND_EN
            if (fmt == FMT_LI) begin
                out_err_n = 1'b0;
                if (in_range(imm, IMM12_MIN, IMM12_MAX)) begin
                    out_inst_n = {imm[11:0], 5'd0, 3'b000, rd, OP_IMM};
                end else begin
                    // Round the upper part up when lo is negative so LUI+ADDI sums to imm.
                    out_inst_n = {imm[31:12] + {19'd0, imm[11]}, rd, OP_LUI};
                    out_last_n = 1'b0;
                    lo_n       = imm[11:0];
                    rd_n       = rd;
                    state_n    = LI_HI;
                end
            end
`endif
        end else if (drain) begin
            out_valid_n = 1'b0;
`ifdef LI_EXPAND_EN
            if (state == LI_HI) begin
                out_valid_n = 1'b1;
                out_inst_n  = {lo_q, rd_q, 3'b000, rd_q, OP_IMM};
                out_err_n   = 1'b0;
                out_last_n  = 1'b1;
                state_n     = IDLE;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            out_inst  <= out_inst_n;
            out_err   <= out_err_n;
            out_last  <= out_last_n;
        end
    end

`ifdef LI_EXPAND_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= 12'd0;
            rd_q <= 5'd0;
        end else begin
            lo_q <= lo_n;
            rd_q <= rd_n;
        end
    end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder (honours LI_EXPAND_EN)
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;

    int checks = 0;
    int failures = 0;

`ifdef LI_EXPAND_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h00000013;

    inst_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] w0;
        logic [31:0] w1;
        int          n;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Reference model: field placement by shift/mask arithmetic on integers.
    function automatic void model(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [31:0] iv, input logic [31:0] pv,
                                  output logic [31:0] w0, output logic [31:0] w1,
                                  output int n, output logic err);
        logic [31:0] o, opw, f3w, rdw, r1w, r2w, hi;
        longint      si, so;
        bit          ok;
        o   = iv - pv;
        si  = longint'($signed(iv));
        so  = longint'($signed(o));
        opw = 32'(op); f3w = 32'(f3); rdw = 32'(rdv); r1w = 32'(r1); r2w = 32'(r2);
        n = 1; w0 = 32'd0; w1 = 32'd0; ok = 1'b0;
        case (f)
            3'd0: begin
                ok = (si >= -2048) && (si <= 2047);
                w0 = ((iv & 32'hFFF) << 20) | (r1w << 15) | (f3w << 12) | (rdw << 7) | opw;
            end
            3'd1: begin
                ok = (si >= -2048) && (si <= 2047);
                w0 = (((iv >> 5) & 32'h7F) << 25) | (r2w << 20) | (r1w << 15) | (f3w << 12)
                   | ((iv & 32'h1F) << 7) | opw;
            end
            3'd2: begin
                ok = (so >= -4096) && (so <= 4094) && ((o & 32'd1) == 32'd0);
                w0 = (((o >> 12) & 32'd1) << 31) | (((o >> 5) & 32'h3F) << 25) | (r2w << 20)
                   | (r1w << 15) | (f3w << 12) | (((o >> 1) & 32'hF) << 8)
                   | (((o >> 11) & 32'd1) << 7) | opw;
            end
            3'd3: begin
                ok = (so >= -1048576) && (so <= 1048574) && ((o & 32'd1) == 32'd0);
                w0 = (((o >> 20) & 32'd1) << 31) | (((o >> 1) & 32'h3FF) << 21)
                   | (((o >> 11) & 32'd1) << 20) | (((o >> 12) & 32'hFF) << 12) | (rdw << 7) | opw;
            end
            3'd4: begin
                ok = (iv % 4096) == 0;
                w0 = iv | (rdw << 7) | opw;
            end
            3'd5: begin
                if (LI_EN) begin
                    ok = 1'b1;
                    if ((si >= -2048) && (si <= 2047)) begin
                        w0 = ((iv & 32'hFFF) << 20) | (rdw << 7) | 32'h13;
                    end else begin
                        hi = (iv + 32'h800) >> 12;
                        w0 = (hi << 12) | (rdw << 7) | 32'h37;
                        w1 = ((iv & 32'hFFF) << 20) | (rdw << 15) | (rdw << 7) | 32'h13;
                        n  = 2;
                    end
                end
            end
            default: ok = 1'b0;
        endcase
        err = !ok;
        if (err) begin
            w0 = NOP;
            n  = 1;
        end
    endfunction

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] iv, input logic [31:0] pv, input string name);
        int k;
        k = 0;
        fmt = f; opcode = op; funct3 = f3; rd = rdv; rs1 = r1; rs2 = r2; imm = iv; pc = pv;
        in_valid = 1'b1;
        #1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) timeout({name, " accept"});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_words(input logic [31:0] w0, input logic [31:0] w1, input int n,
                                input logic err, input string name, input bit bp);
        for (int i = 0; i < n; i++) begin
            int          k;
            bit          done, held;
            logic [31:0] ew, prev;
            k = 0; done = 0; held = 0; prev = '0;
            ew = (i == 0) ? w0 : w1;
            @(negedge clk);
            while (!done && k < 50) begin
                out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (out_valid) begin
                    if (held) chk({name, " hold"}, out_inst, prev);
                    if (out_ready) begin
                        chk({name, " inst"}, out_inst, ew);
                        chk({name, " err"}, 32'(out_err), (i == 0) ? 32'(err) : 32'd0);
                        chk({name, " last"}, 32'(out_last), (i == n - 1) ? 32'd1 : 32'd0);
                        if (n == 2 && i == 0) chk({name, " ready_mid"}, 32'(in_ready), 32'd0);
                        done = 1;
                    end else begin
                        held = 1;
                        prev = out_inst;
                    end
                end
                if (!done) begin
                    @(negedge clk);
                    k++;
                end
            end
            if (!done) timeout({name, " output"});
        end
        out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] w0, w1;
        int          n;
        logic        e;
        logic [31:0] bb_exp[4];

        #1 rst = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_inst", out_inst, 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset out_last", 32'(out_last), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        tbl.push_back(vec_t'{"i_addi",  3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5,        32'd0,     32'h00500093, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"i_min",   3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'd0,     32'h80000093, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"i_over",  3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'd0,     NOP,          32'd0, 1, 1'b1});
        tbl.push_back(vec_t'{"s_neg",   3'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC, 32'd0,     32'hFE312E23, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"sb_back", 3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h000000F0, 32'h100,   32'hFE2088E3, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"sb_odd",  3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h000000F1, 32'h100,   NOP,          32'd0, 1, 1'b1});
        tbl.push_back(vec_t'{"sb_max",  3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h00000FFE, 32'd0,     32'h7E208FE3, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"sb_over", 3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h00001000, 32'd0,     NOP,          32'd0, 1, 1'b1});
        tbl.push_back(vec_t'{"uj_fwd",  3'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8,        32'd0,     32'h008000EF, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"uj_max",  3'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h000FFFFE, 32'd0,     32'h7FFFF0EF, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"uj_odd",  3'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd9,        32'd0,     NOP,          32'd0, 1, 1'b1});
        tbl.push_back(vec_t'{"u_ok",    3'd4, 7'h37, 3'd0, 5'd3, 5'd0, 5'd0, 32'h12345000, 32'd0,     32'h123451B7, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"u_low",   3'd4, 7'h37, 3'd0, 5'd3, 5'd0, 5'd0, 32'h12345001, 32'd0,     NOP,          32'd0, 1, 1'b1});
        tbl.push_back(vec_t'{"fmt7",    3'd7, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,        32'd0,     NOP,          32'd0, 1, 1'b1});
        tbl.push_back(vec_t'{"li_big",  3'd5, 7'h7F, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 32'd0,     32'h123462B7, 32'hFFF28293, 2, 1'b0});
        tbl.push_back(vec_t'{"li_neg",  3'd5, 7'h7F, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFF9, 32'd0,     32'hFF900293, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"li_2047", 3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h000007FF, 32'd0,     32'h7FF00293, 32'd0, 1, 1'b0});
        tbl.push_back(vec_t'{"li_2048", 3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h00000800, 32'd0,     32'h000012B7, 32'h80028293, 2, 1'b0});

        @(negedge clk);
        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            if (v.f == 3'd5 && !LI_EN) begin
                v.w0 = NOP; v.n = 1; v.err = 1'b1;
            end
            send(v.f, v.op, v.f3, v.rd, v.rs1, v.rs2, v.imm, v.pc, v.name);
            expect_words(v.w0, v.w1, v.n, v.err, v.name, 1'b0);
        end

        // Backpressure: output must freeze and block new requests.
        send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, "bp");
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp inst", out_inst, 32'h00500093);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp drained", 32'(out_valid), 32'd0);

        // Back-to-back single-word requests at full rate.
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                chk("b2b inst", out_inst, bb_exp[k-1]);
                chk("b2b valid", 32'(out_valid), 32'd1);
                chk("b2b in_ready", 32'(in_ready), 32'd1);
            end
            if (k < 4) begin
                fmt = 3'd0; opcode = 7'h13; funct3 = 3'(k); rd = 5'(k + 1); rs1 = 5'(k + 2);
                imm = 32'(k * 3); pc = 32'd0; in_valid = 1'b1;
                model(fmt, opcode, funct3, rd, rs1, rs2, imm, pc, w0, w1, n, e);
                bb_exp[k] = w0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b idle", 32'(out_valid), 32'd0);

        // Reset while a multi-word request is in flight.
`ifdef LI_EXPAND_EN
        send(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 32'd0, "rst_mid");
`else
        send(3'd0, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 32'd7, 32'd0, "rst_mid");
`endif
        @(negedge clk);
        chk("rst_mid pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid valid", 32'(out_valid), 32'd0);
        chk("rst_mid in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, "post_rst");
        expect_words(32'h00500093, 32'd0, 1, 1'b0, "post_rst", 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst no_stale", 32'(out_valid), 32'd0);
        end

        // Randomised requests with random backpressure against the model.
        for (int t = 0; t < 150; t++) begin
            logic [2:0]  rf;
            logic [31:0] ri, rp;
            int          sel;
            rf  = 3'($urandom_range(0, 7));
            rp  = $urandom & 32'hFFFFFFFC;
            sel = $urandom_range(0, 3);
            case (sel)
                0: ri = $urandom;
                1: ri = 32'($urandom_range(0, 6000)) - 32'd3000;
                2: ri = rp + 32'($urandom_range(0, 8192)) - 32'd4096;
                default: ri = rp + 32'($urandom_range(0, 1 << 22)) - 32'(1 << 21);
            endcase
            if (rf == 3'd4 && $urandom_range(0, 1) == 1) ri = ri & 32'hFFFFF000;
            model(rf, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  ri, rp, w0, w1, n, e);
            send(rf, opcode, funct3, rd, rs1, rs2, ri, rp, "rand");
            model(fmt, opcode, funct3, rd, rs1, rs2, imm, pc, w0, w1, n, e);
            expect_words(w0, w1, n, e, "rand", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
